// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, decode queue and execute.
// Modports: master (fetch/execute side), slave (queue side).
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_dec_inst;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [15:0]     out_imm;
  logic [31:0]     out_imm_ext;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  logic            halted;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_dec_inst, out_rs,
    input  out_rt, out_rd, out_shamt, out_imm,
    input  out_imm_ext, out_pc, out_illegal,
    input  halted, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_dec_inst, out_rs,
    output out_rt, out_rd, out_shamt, out_imm,
    output out_imm_ext, out_pc, out_illegal,
    output halted, count
  );
endinterface

// File: rtl/decode_queue.sv
// MIPS decode + FIFO queue with RUN/HALTED state; decode at enqueue.
// Ports: clk, rst_n (sync, active low), q (decode_queue_if.slave).
// Option: DECODE_ILLEGAL_TRAP_EN stores an illegal-encoding flag.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [5:0] INST_NOP   = 6'd0;
  localparam logic [5:0] INST_ADDU  = 6'd1;
  localparam logic [5:0] INST_SUBU  = 6'd2;
  localparam logic [5:0] INST_SLT   = 6'd3;
  localparam logic [5:0] INST_JR    = 6'd4;
  localparam logic [5:0] INST_ORI   = 6'd5;
  localparam logic [5:0] INST_LW    = 6'd6;
  localparam logic [5:0] INST_SW    = 6'd7;
  localparam logic [5:0] INST_BEQ   = 6'd8;
  localparam logic [5:0] INST_ADDI  = 6'd9;
  localparam logic [5:0] INST_ADDIU = 6'd10;
  localparam logic [5:0] INST_J     = 6'd11;
  localparam logic [5:0] INST_JAL   = 6'd12;
  localparam logic [5:0] INST_HLT   = 6'd13;
  localparam logic [5:0] INST_LUI   = 6'd14;

  typedef struct packed {
    logic [5:0]      dec;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [15:0]     imm;
    logic [31:0]     imm_ext;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic {RUN, HALTED} state_e;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_sh;
  logic [15:0] f_imm;
  logic        sp;
  logic [5:0]  dec;
  logic        legal;
  entry_t      new_e;

  assign op    = q.in_inst[31:26];
  assign f_rs  = q.in_inst[25:21];
  assign f_rt  = q.in_inst[20:16];
  assign f_rd  = q.in_inst[15:11];
  assign f_sh  = q.in_inst[10:6];
  assign fn    = q.in_inst[5:0];
  assign f_imm = q.in_inst[15:0];
  assign sp    = (op == 6'h00);

  always_comb begin
    dec   = INST_NOP;
    legal = 1'b0;
    unique case (1'b1)
      sp && fn == 6'h21 && f_sh == 5'd0: begin
        dec = INST_ADDU; legal = 1'b1;
      end
      sp && fn == 6'h23 && f_sh == 5'd0: begin
        dec = INST_SUBU; legal = 1'b1;
      end
      sp && fn == 6'h2a && f_sh == 5'd0: begin
        dec = INST_SLT; legal = 1'b1;
      end
      sp && fn == 6'h08 && f_rt == 5'd0
         && f_rd == 5'd0: begin
        dec = INST_JR; legal = 1'b1;
      end
      op == 6'h0d: begin
        dec = INST_ORI; legal = 1'b1;
      end
      op == 6'h23: begin
        dec = INST_LW; legal = 1'b1;
      end
      op == 6'h2b: begin
        dec = INST_SW; legal = 1'b1;
      end
      op == 6'h04: begin
        dec = INST_BEQ; legal = 1'b1;
      end
      op == 6'h08: begin
        dec = INST_ADDI; legal = 1'b1;
      end
      op == 6'h09: begin
        dec = INST_ADDIU; legal = 1'b1;
      end
      op == 6'h02: begin
        dec = INST_J; legal = 1'b1;
      end
      op == 6'h03: begin
        dec = INST_JAL; legal = 1'b1;
      end
      op == 6'h3f: begin
        dec = INST_HLT; legal = 1'b1;
      end
      op == 6'h0f && f_rs == 5'd0: begin
        dec = INST_LUI; legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    new_e       = '0;
    new_e.dec   = dec;
    new_e.rs    = f_rs;
    new_e.rt    = f_rt;
    new_e.rd    = f_rd;
    new_e.shamt = f_sh;
    new_e.imm   = f_imm;
    new_e.pc    = q.in_pc;
    // ORI/LUI use a logical immediate; all else is signed
    if (dec == INST_ORI || dec == INST_LUI)
      new_e.imm_ext = {16'h0, f_imm};
    else
      new_e.imm_ext = {{16{f_imm[15]}}, f_imm};
  end

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] wptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  state_e        state_q;
  state_e        state_d;
  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign enq   = q.in_valid && q.in_ready;
  assign deq   = q.out_valid && q.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (q.flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) begin
        mem_q[wptr_q] <= new_e;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (deq)
        rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic ill_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        ill_q[i] <= 1'b0;
    end else if (!q.flush && enq) begin
      ill_q[wptr_q] <= !legal;
    end
  end

  assign q.out_illegal = ill_q[rptr_q];
`else
  logic unused_legal;
  assign unused_legal  = legal;
  assign q.out_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:
        if (q.flush)
          state_d = RUN;
        else if (enq && dec == INST_HLT)
          state_d = HALTED;
      HALTED:
        if (q.flush)
          state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    q.halted   = (state_q == HALTED);
    q.in_ready = !full && (state_q == RUN);
  end

  assign q.out_valid    = !empty;
  assign q.count        = cnt_q;
  assign q.out_dec_inst = mem_q[rptr_q].dec;
  assign q.out_rs       = mem_q[rptr_q].rs;
  assign q.out_rt       = mem_q[rptr_q].rt;
  assign q.out_rd       = mem_q[rptr_q].rd;
  assign q.out_shamt    = mem_q[rptr_q].shamt;
  assign q.out_imm      = mem_q[rptr_q].imm;
  assign q.out_imm_ext  = mem_q[rptr_q].imm_ext;
  assign q.out_pc       = mem_q[rptr_q].pc;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, PC_W=32).
// Honours DECODE_ILLEGAL_TRAP_EN for the illegal-flag expectation.
module tb_decode_queue;
  localparam logic [5:0] NOP   = 6'd0;
  localparam logic [5:0] ADDU  = 6'd1;
  localparam logic [5:0] ORI   = 6'd5;
  localparam logic [5:0] ADDI  = 6'd9;
  localparam logic [5:0] ADDIU = 6'd10;
  localparam logic [5:0] HLT   = 6'd13;
  localparam logic [5:0] LUI   = 6'd14;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(4), .PC_W(32)) dq ();

  decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (dq.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst,
                       input logic [31:0] pc);
    dq.in_valid = 1'b1;
    dq.in_inst  = inst;
    dq.in_pc    = pc;
  endtask

  initial begin
    rst_n        = 1'b0;
    dq.flush     = 1'b0;
    dq.in_valid  = 1'b0;
    dq.in_inst   = '0;
    dq.in_pc     = '0;
    dq.out_ready = 1'b0;
    step();
    step();
    check("rst_count", 32'(dq.count), 0);
    check("rst_oval", 32'(dq.out_valid), 0);
    check("rst_irdy", 32'(dq.in_ready), 1);
    check("rst_halt", 32'(dq.halted), 0);
    check("rst_ill", 32'(dq.out_illegal), 0);
    check("rst_dec", 32'(dq.out_dec_inst), 32'(NOP));
    check("rst_pc", dq.out_pc, 0);
    rst_n = 1'b1;
    step();

    // single ADDU, consumer always ready
    dq.out_ready = 1'b1;
    offer(32'h0022_1821, 32'h100);
    step();
    dq.in_valid = 1'b0;
    check("s_oval", 32'(dq.out_valid), 1);
    check("s_dec", 32'(dq.out_dec_inst), 32'(ADDU));
    check("s_rs", 32'(dq.out_rs), 1);
    check("s_rt", 32'(dq.out_rt), 2);
    check("s_rd", 32'(dq.out_rd), 3);
    check("s_pc", dq.out_pc, 32'h100);
    step();
    check("s_cnt0", 32'(dq.count), 0);
    check("s_oval0", 32'(dq.out_valid), 0);

    // ADDU with nonzero shamt is not legal
    dq.out_ready = 1'b0;
    offer(32'h0022_1861, 32'h104);
    step();
    dq.in_valid = 1'b0;
    check("sh_dec", 32'(dq.out_dec_inst), 32'(NOP));
    check("sh_ill", 32'(dq.out_illegal), 32'(ILL_EXP));
    dq.out_ready = 1'b1;
    step();

    // fill to DEPTH with ADDIU imm=i
    dq.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h2401_0000 | i, 32'h200 + 4 * i);
      step();
    end
    check("f_irdy", 32'(dq.in_ready), 0);
    check("f_cnt", 32'(dq.count), 4);
    offer(32'h2401_00AA, 32'h2F0);
    step();
    check("f_hold", 32'(dq.count), 4);
    dq.in_valid  = 1'b0;
    dq.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("d_pc", dq.out_pc, 32'h200 + 4 * i);
      check("d_imm", 32'(dq.out_imm), i);
      check("d_dec", 32'(dq.out_dec_inst), 32'(ADDIU));
      step();
    end
    check("d_cnt", 32'(dq.count), 0);

    // second round wraps pointers; overlap enq/deq
    dq.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(32'h2401_0010 | i, 32'h300 + 4 * i);
      step();
    end
    dq.out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      check("w_pc", dq.out_pc, 32'h300 + 4 * (i - 2));
      offer(32'h2401_0010 | i, 32'h300 + 4 * i);
      step();
      check("w_cnt", 32'(dq.count), 2);
    end
    dq.in_valid = 1'b0;
    for (int i = 2; i < 4; i++) begin
      check("w_pc2", dq.out_pc, 32'h300 + 4 * i);
      check("w_imm", 32'(dq.out_imm), 32'h10 + i);
      step();
    end
    check("w_cnt0", 32'(dq.count), 0);

    // immediate extension
    dq.out_ready = 1'b0;
    offer(32'h2001_FFFF, 32'h400);
    step();
    check("x_addi", 32'(dq.out_dec_inst), 32'(ADDI));
    check("x_sext", dq.out_imm_ext, 32'hFFFF_FFFF);
    dq.out_ready = 1'b1;
    offer(32'h3401_FFFF, 32'h404);
    step();
    dq.in_valid = 1'b0;
    check("x_ori", 32'(dq.out_dec_inst), 32'(ORI));
    check("x_zext", dq.out_imm_ext, 32'h0000_FFFF);
    step();
    check("x_cnt0", 32'(dq.count), 0);

    // halt
    dq.out_ready = 1'b0;
    offer(32'hFC00_0000, 32'h500);
    step();
    offer(32'h0022_1821, 32'h504);
    check("h_halt", 32'(dq.halted), 1);
    check("h_irdy", 32'(dq.in_ready), 0);
    check("h_dec", 32'(dq.out_dec_inst), 32'(HLT));
    step();
    check("h_cnt1", 32'(dq.count), 1);
    dq.out_ready = 1'b1;
    step();
    check("h_drain", 32'(dq.count), 0);
    check("h_still", 32'(dq.halted), 1);
    dq.in_valid = 1'b0;
    dq.flush    = 1'b1;
    step();
    dq.flush = 1'b0;
    check("h_fhalt", 32'(dq.halted), 0);
    check("h_firdy", 32'(dq.in_ready), 1);

    // illegal LUI (rs!=0) then legal LUI
    dq.out_ready = 1'b0;
    offer(32'h3C21_0001, 32'h600);
    step();
    offer(32'h3C01_0001, 32'h604);
    check("i_dec", 32'(dq.out_dec_inst), 32'(NOP));
    check("i_ill", 32'(dq.out_illegal), 32'(ILL_EXP));
    step();
    dq.in_valid  = 1'b0;
    dq.out_ready = 1'b1;
    step();
    check("l_dec", 32'(dq.out_dec_inst), 32'(LUI));
    check("l_ill", 32'(dq.out_illegal), 0);
    check("l_ext", dq.out_imm_ext, 32'h0000_0001);
    step();

    // reset with three queued entries
    dq.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h2401_0020 | i, 32'h700 + 4 * i);
      step();
    end
    check("r_cnt3", 32'(dq.count), 3);
    rst_n = 1'b0;
    step();
    dq.in_valid = 1'b0;
    rst_n       = 1'b1;
    check("r_cnt", 32'(dq.count), 0);
    check("r_oval", 32'(dq.out_valid), 0);
    check("r_irdy", 32'(dq.in_ready), 1);
    check("r_pc", dq.out_pc, 0);
    check("r_dec", 32'(dq.out_dec_inst), 32'(NOP));

    // flush wins over same-cycle enqueue and dequeue
    for (int i = 0; i < 2; i++) begin
      offer(32'h2401_0030 | i, 32'h800 + 4 * i);
      step();
    end
    check("fl_cnt2", 32'(dq.count), 2);
    offer(32'h2401_0040, 32'h900);
    dq.out_ready = 1'b1;
    dq.flush     = 1'b1;
    step();
    dq.flush    = 1'b0;
    dq.in_valid = 1'b0;
    check("fl_cnt", 32'(dq.count), 0);
    check("fl_oval", 32'(dq.out_valid), 0);
    step();
    check("fl_drop", 32'(dq.count), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
